traffic_phase_timer: RTL and testbench
======================================

# traffic_phase_timer

Demand-aware phase timer feeding the four-way traffic light controller. It divides `clk` down to a one-second tick and keeps the elapsed seconds of the current phase. It decodes the current phase from the controller's light outputs and generates the `five_sec_timer` (green done) and `one_sec_timer` (yellow done) inputs the controller sequences on. Green time is extended while the green direction still has vehicles and no other direction is waiting, bounded by min/max limits.

## Interface
- `CLK_PER_SEC`, 50_000_000: clk cycles per second tick (≥2).
- `MIN_GREEN`, 5: minimum green seconds (≥1).
- `MAX_GREEN`, 15: maximum green seconds (≥ MIN_GREEN).
- `YELLOW_TIME`, 1: yellow seconds (≥1).
- `clk` in 1: system clock, single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `rst_count` in 1: controller phase-change strobe; clears counters and done flags.
- `n_light`, `e_light`, `s_light`, `w_light` in 2 each: controller lights (00 red, 01 yellow, 10 green, 11 illegal).
- `car_req` in 4: vehicle sensors, bit 3..0 = N,E,S,W, level.
- `five_sec_timer` out 1: green-done level to controller.
- `one_sec_timer` out 1: yellow-done level to controller.
- `sec_tick` out 1: one-cycle pulse per second.
- `elapsed` out 8: seconds in current phase, saturating at 255.
- `fault` out 1: sticky illegal-light indication.

## Operation
- Phase decode (combinational):
  - GREEN: exactly one light = 10; `gdir` = its index.
  - YELLOW: no green, ≥1 yellow, not all four yellow.
  - IDLE: all four yellow.
  - ILLEGAL: ≥2 greens or any light = 11.
- Prescaler `pcnt` counts 0..CLK_PER_SEC-1 and wraps. `sec_tick` = (`pcnt` == CLK_PER_SEC-1), gated off in IDLE and when `fault` is set.
- `elapsed` increments on each `sec_tick` edge and saturates at 255.
- Clear conditions: `rst_count`=1, phase IDLE, or `gdir` differing from the registered `gdir` of the previous cycle. Any of these sets `pcnt`, `elapsed`, `five_sec_timer` and `one_sec_timer` to 0 at the next edge. Clear has priority over increment and over done-set.
- Demand latch `dem[3:0]`:
  - `dem[i]` is set while `car_req[i]`=1.
  - `dem[gdir]` is cleared every cycle in GREEN.
  - Set and clear in the same cycle for the same bit: clear wins.
  - `conflict` = |(`dem` & ~onehot(`gdir`)).
- Green done: on a `sec_tick` edge in GREEN with e = `elapsed`+1 (saturated), set `five_sec_timer` when:
  - e ≥ MAX_GREEN, or
  - e ≥ MIN_GREEN and (`car_req[gdir]`=0 or `conflict`=1).

  Once set, it stays high until a clear condition.
- Yellow done: on a `sec_tick` edge in YELLOW with `elapsed`+1 ≥ YELLOW_TIME, set `one_sec_timer`. It holds until cleared.
- `five_sec_timer` is only set in GREEN and `one_sec_timer` only in YELLOW. Both are never high together.
- Fault:
  - ILLEGAL phase for 1 cycle sets `fault`, which stays set until `reset_n`.
  - While `fault`=1: both done outputs forced 0, `sec_tick` 0, `elapsed` frozen.

## Timing
- Reset (async, `reset_n`=0): `pcnt`=0, `elapsed`=0, `dem`=0, registered `gdir`=0. All outputs 0.
- All outputs are registered except `sec_tick`, which decodes registered `pcnt`.
- After a clear edge k, `elapsed` = N at edge k+N·CLK_PER_SEC.
- Done flag rises on the same edge its threshold `elapsed` value is written, so minimum green lasts MIN_GREEN·CLK_PER_SEC cycles after `rst_count`.
- The controller samples the done level and pulses `rst_count` in the same cycle. The done flag drops at the following edge. No pulse stretching is required.
- `rst_count` with a coincident `sec_tick`: counters go to 0 and the tick is discarded.
- Reset deasserted mid-phase: counting restarts from 0 in whatever phase is decoded.

## Test plan
- CLK_PER_SEC=4, MIN=5, MAX=15, YELLOW=1. N green, `car_req`=0, `rst_count` pulsed at edge 0 → `five_sec_timer` rises at edge 20; `elapsed`=5.
- Same setup, `car_req[N]`=1 held, no other requests → green extends, `five_sec_timer` rises at edge 60 (`elapsed`=15).
- `car_req[N]`=1 held, `car_req[E]` pulsed at edge 30 → `five_sec_timer` rises at edge 32 (`elapsed`=8).
- Yellow phase (N=01, E=01) after `rst_count` → `one_sec_timer` at edge 4. `rst_count` at edge 5 → `one_sec_timer` low at edge 6, `elapsed`=0.
- All four yellow for 10 cycles → `sec_tick` never asserts, outputs 0. Then N green → first `sec_tick` 4 cycles later.
- `n_light`=10 and `e_light`=10 simultaneously for 1 cycle → `fault`=1 the next edge and stays set, done outputs 0. Asserting `reset_n`=0 clears it asynchronously.

Source files
------------

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
//
// Purpose:
//   Phase timer for a four-way traffic light controller. Divides clk down to a
//   one-second tick, tracks elapsed seconds of the current phase, decodes the
//   phase from the controller's light outputs and produces the green-done and
//   yellow-done levels the controller sequences on. Green is extended while
//   the green approach still has traffic and nobody else is waiting, bounded
//   by MIN_GREEN / MAX_GREEN.
//
// Parameters:
//   CLK_PER_SEC  clk cycles per one-second tick (>= 2)
//   MIN_GREEN    minimum green seconds (>= 1)
//   MAX_GREEN    maximum green seconds (>= MIN_GREEN)
//   YELLOW_TIME  yellow seconds (>= 1)
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   rst_count       controller phase-change strobe, clears counters and flags
//   n/e/s/w_light   controller lights: 00 red, 01 yellow, 10 green, 11 illegal
//   car_req[3:0]    vehicle sensors, bit 3..0 = N,E,S,W (level)
//   five_sec_timer  green-done level (registered)
//   one_sec_timer   yellow-done level (registered)
//   sec_tick        one-cycle pulse per second (decoded from prescaler)
//   elapsed[7:0]    seconds in current phase, saturating at 255 (registered)
//   fault           sticky illegal-light indication (registered)
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 15,
  parameter int YELLOW_TIME = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rst_count,
  input  logic [1:0] n_light,
  input  logic [1:0] e_light,
  input  logic [1:0] s_light,
  input  logic [1:0] w_light,
  input  logic [3:0] car_req,
  output logic       five_sec_timer,
  output logic       one_sec_timer,
  output logic       sec_tick,
  output logic [7:0] elapsed,
  output logic       fault
);

  localparam int          PW        = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [31:0] MIN_U     = MIN_GREEN;
  localparam logic [31:0] MAX_U     = MAX_GREEN;
  localparam logic [31:0] YEL_U     = YELLOW_TIME;

  // Decoded phase of the intersection (combinational, not a stored state).
  typedef enum logic [2:0] {
    PH_RED     = 3'd0,  // no green, no yellow
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_IDLE    = 3'd3,  // all four yellow (flashing / standby)
    PH_ILLEGAL = 3'd4
  } phase_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0]    elapsed_q, elapsed_d;
  logic          five_q, five_d;
  logic          one_q, one_d;
  logic          fault_q, fault_d;
  logic [3:0]    dem_q, dem_d;
  logic [1:0]    gdir_q, gdir_d;

  // ---------------------------------------------------------------------------
  // Phase decode
  // ---------------------------------------------------------------------------
  logic [1:0] light [4];
  logic [3:0] is_green;
  logic [3:0] is_yellow;
  logic [3:0] is_bad;

  // Index matches car_req: 3=N, 2=E, 1=S, 0=W.
  assign light[3] = n_light;
  assign light[2] = e_light;
  assign light[1] = s_light;
  assign light[0] = w_light;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_light
      assign is_green[gi]  = (light[gi] == 2'b10);
      assign is_yellow[gi] = (light[gi] == 2'b01);
      assign is_bad[gi]    = (light[gi] == 2'b11);
    end
  endgenerate

  phase_e     phase;
  logic       multi_green;
  logic [1:0] gdir_raw;
  logic [1:0] gdir;
  logic [3:0] gdir_onehot;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_green = |(is_green & (is_green - 4'd1));

  always_comb begin
    phase = PH_RED;
    if ((|is_bad) || multi_green) begin
      phase = PH_ILLEGAL;
    end else if (&is_yellow) begin
      phase = PH_IDLE;
    end else if (|is_green) begin
      phase = PH_GREEN;
    end else if (|is_yellow) begin
      phase = PH_YELLOW;
    end
  end

  always_comb begin
    gdir_raw = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (is_green[i]) begin
        gdir_raw = 2'(i);
      end
    end
  end

  // Outside GREEN the direction reads as 0, which is also its reset value.
  assign gdir        = (phase == PH_GREEN) ? gdir_raw : 2'd0;
  assign gdir_onehot = 4'b0001 << gdir;

  // ---------------------------------------------------------------------------
  // Tick, clear and threshold logic
  // ---------------------------------------------------------------------------
  logic        clear;
  logic        conflict;
  logic [7:0]  elapsed_inc;
  logic [31:0] e_wide;
  logic        ge_min;
  logic        ge_max;
  logic        ge_yel;
  logic        green_done;

  assign sec_tick = (pcnt_q == PCNT_MAX) && (phase != PH_IDLE) && !fault_q;

  assign clear = rst_count || (phase == PH_IDLE) || (gdir != gdir_q);

  // Another approach has latched demand while this one is green.
  assign conflict = |(dem_q & ~gdir_onehot);

  // Value elapsed would take on this tick; thresholds compare against it so
  // the done flag rises on the same edge the threshold count is written.
  assign elapsed_inc = (elapsed_q == 8'hFF) ? 8'hFF : elapsed_q + 8'd1;
  assign e_wide      = {24'd0, elapsed_inc};
  assign ge_min      = (e_wide >= MIN_U);
  assign ge_max      = (e_wide >= MAX_U);
  assign ge_yel      = (e_wide >= YEL_U);
  assign green_done  = ge_max || (ge_min && (!car_req[gdir] || conflict));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pcnt_d    = pcnt_q;
    elapsed_d = elapsed_q;
    five_d    = five_q;
    one_d     = one_q;
    fault_d   = fault_q || (phase == PH_ILLEGAL);
    gdir_d    = gdir;
    // Clear wins over set for the green approach's own demand bit.
    dem_d     = (dem_q | car_req) & ~((phase == PH_GREEN) ? gdir_onehot : 4'b0000);

    if (fault_q) begin
      // Timing frozen; done levels held low until reset.
      five_d = 1'b0;
      one_d  = 1'b0;
    end else if (clear) begin
      // A coincident tick is discarded here.
      pcnt_d    = '0;
      elapsed_d = 8'd0;
      five_d    = 1'b0;
      one_d     = 1'b0;
    end else begin
      pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PW'(1);
      if (sec_tick) begin
        elapsed_d = elapsed_inc;
        // Setting one done flag drops the other so they are never both high,
        // even across a W-green to yellow change where the direction code
        // does not move.
        if ((phase == PH_GREEN) && green_done) begin
          five_d = 1'b1;
          one_d  = 1'b0;
        end
        if ((phase == PH_YELLOW) && ge_yel) begin
          one_d  = 1'b1;
          five_d = 1'b0;
        end
      end
    end

    // Fault becomes visible on this edge; done levels drop together with it.
    if (phase == PH_ILLEGAL) begin
      five_d = 1'b0;
      one_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q    <= '0;
      elapsed_q <= 8'd0;
      five_q    <= 1'b0;
      one_q     <= 1'b0;
      fault_q   <= 1'b0;
      dem_q     <= 4'd0;
      gdir_q    <= 2'd0;
    end else begin
      pcnt_q    <= pcnt_d;
      elapsed_q <= elapsed_d;
      five_q    <= five_d;
      one_q     <= one_d;
      fault_q   <= fault_d;
      dem_q     <= dem_d;
      gdir_q    <= gdir_d;
    end
  end

  assign five_sec_timer = five_q;
  assign one_sec_timer  = one_q;
  assign elapsed        = elapsed_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_timer
//
// Directed scenarios plus randomized phase sequences, all checked against a
// cycle-level behavioural model of the timer rules (seconds, demand set,
// thresholds) kept in plain integers.
// -----------------------------------------------------------------------------
module tb_traffic_phase_timer;

  localparam int C    = 4;
  localparam int MINS = 5;
  localparam int MAXS = 15;
  localparam int YT   = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rst_count;
  logic [1:0] n_light, e_light, s_light, w_light;
  logic [3:0] car_req;
  logic       five_sec_timer, one_sec_timer, sec_tick, fault;
  logic [7:0] elapsed;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .CLK_PER_SEC(C),
    .MIN_GREEN  (MINS),
    .MAX_GREEN  (MAXS),
    .YELLOW_TIME(YT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rst_count     (rst_count),
    .n_light       (n_light),
    .e_light       (e_light),
    .s_light       (s_light),
    .w_light       (w_light),
    .car_req       (car_req),
    .five_sec_timer(five_sec_timer),
    .one_sec_timer (one_sec_timer),
    .sec_tick      (sec_tick),
    .elapsed       (elapsed),
    .fault         (fault)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference model state
  int       m_pcnt, m_el, m_five, m_one, m_fault, m_gprev;
  bit [3:0] m_dem;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pcnt = 0; m_el = 0; m_five = 0; m_one = 0; m_fault = 0; m_gprev = 0;
    m_dem = 4'd0;
  endtask

  // lights packed as {N,E,S,W}
  task automatic set_lights(input logic [7:0] l);
    {n_light, e_light, s_light, w_light} = l;
  endtask

  // One clock: inputs already driven at negedge. Checks sec_tick before the
  // edge and registered outputs after it.
  task automatic step_cycle();
    int ng, ny, nb, gd, e;
    int n_pcnt, n_el, n_five, n_one, n_fault;
    bit illegal, idle, green, yellow, tick, clr, conflict;
    logic [1:0] lt [4];
    bit [3:0] n_dem;
    #1;
    lt[3] = n_light; lt[2] = e_light; lt[1] = s_light; lt[0] = w_light;
    ng = 0; ny = 0; nb = 0; gd = 0;
    for (int i = 0; i < 4; i++) begin
      if (lt[i] == 2'b10) begin ng++; gd = i; end
      if (lt[i] == 2'b01) ny++;
      if (lt[i] == 2'b11) nb++;
    end
    illegal = (nb > 0) || (ng > 1);
    idle    = !illegal && (ny == 4);
    green   = !illegal && (ng == 1);
    yellow  = !illegal && (ng == 0) && (ny > 0) && (ny < 4);
    if (!green) gd = 0;

    tick = (m_pcnt == C - 1) && !idle && (m_fault == 0);
    chk("sec_tick", int'(sec_tick), int'(tick));

    clr = rst_count || idle || (gd != m_gprev);
    conflict = 0;
    for (int i = 0; i < 4; i++)
      if (i != gd && m_dem[i]) conflict = 1;
    e = (m_el < 255) ? m_el + 1 : 255;

    n_pcnt = m_pcnt; n_el = m_el; n_five = m_five; n_one = m_one;
    if (m_fault != 0) begin
      n_five = 0; n_one = 0;
    end else if (clr) begin
      n_pcnt = 0; n_el = 0; n_five = 0; n_one = 0;
    end else begin
      n_pcnt = (m_pcnt + 1) % C;
      if (tick) begin
        n_el = e;
        if (green && (e >= MAXS || (e >= MINS && (!car_req[gd] || conflict)))) begin
          n_five = 1; n_one = 0;
        end
        if (yellow && e >= YT) begin
          n_one = 1; n_five = 0;
        end
      end
    end
    if (illegal) begin n_five = 0; n_one = 0; end
    n_fault = (m_fault != 0 || illegal) ? 1 : 0;
    n_dem = m_dem | car_req;
    if (green) n_dem[gd] = 1'b0;

    @(posedge clk);
    m_pcnt = n_pcnt; m_el = n_el; m_five = n_five; m_one = n_one;
    m_fault = n_fault; m_dem = n_dem; m_gprev = gd;
    edge_n++;
    @(negedge clk);
    chk("five", int'(five_sec_timer), m_five);
    chk("one", int'(one_sec_timer), m_one);
    chk("elapsed", int'(elapsed), m_el);
    chk("fault", int'(fault), m_fault);
  endtask

  // Called at a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_five", int'(five_sec_timer), 0);
    chk("rst_one", int'(one_sec_timer), 0);
    chk("rst_elapsed", int'(elapsed), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_tick", int'(sec_tick), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int found;
    logic [7:0] l;
    reset_n = 1'b0; rst_count = 1'b0; car_req = 4'd0;
    set_lights(8'h00);
    model_reset();
    @(negedge clk);
    do_reset();

    // N green, no demand: minimum green
    set_lights(8'b10_00_00_00); car_req = 4'b0000; rst_count = 1'b1;
    step_cycle(); rst_count = 1'b0; edge_n = 0;
    for (int k = 1; k <= 20; k++) begin
      step_cycle();
      if (k == 19) chk("t1_five_e19", int'(five_sec_timer), 0);
    end
    chk("t1_five_e20", int'(five_sec_timer), 1);
    chk("t1_elapsed_e20", int'(elapsed), 5);

    // N green with N demand held: extends to MAX
    car_req = 4'b1000; rst_count = 1'b1;
    step_cycle(); rst_count = 1'b0; edge_n = 0;
    for (int k = 1; k <= 60; k++) begin
      step_cycle();
      if (k == 59) chk("t2_five_e59", int'(five_sec_timer), 0);
    end
    chk("t2_five_e60", int'(five_sec_timer), 1);
    chk("t2_elapsed_e60", int'(elapsed), 15);

    // N demand held, E pulses at edge 30: ends at next tick (edge 32)
    car_req = 4'b1000; rst_count = 1'b1;
    step_cycle(); rst_count = 1'b0; edge_n = 0;
    for (int k = 1; k <= 32; k++) begin
      car_req = (k == 30) ? 4'b1100 : 4'b1000;
      step_cycle();
      if (k == 31) chk("t3_five_e31", int'(five_sec_timer), 0);
    end
    chk("t3_five_e32", int'(five_sec_timer), 1);
    chk("t3_elapsed_e32", int'(elapsed), 8);

    // Yellow N+E
    set_lights(8'b01_01_00_00); car_req = 4'b0000; rst_count = 1'b1;
    step_cycle(); rst_count = 1'b0; edge_n = 0;
    for (int k = 1; k <= 4; k++) begin
      step_cycle();
      if (k == 3) chk("t4_one_e3", int'(one_sec_timer), 0);
    end
    chk("t4_one_e4", int'(one_sec_timer), 1);
    step_cycle();
    chk("t4_one_e5", int'(one_sec_timer), 1);
    rst_count = 1'b1;
    step_cycle(); rst_count = 1'b0;
    chk("t4_one_e6", int'(one_sec_timer), 0);
    chk("t4_elapsed_e6", int'(elapsed), 0);

    // All yellow: no ticks, outputs low
    set_lights(8'b01_01_01_01);
    for (int k = 0; k < 10; k++) begin
      step_cycle();
      chk("t5_idle_tick", int'(sec_tick), 0);
      chk("t5_idle_five", int'(five_sec_timer), 0);
      chk("t5_idle_el", int'(elapsed), 0);
    end
    set_lights(8'b10_00_00_00);
    found = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (sec_tick && found < 0) found = k;
      step_cycle();
    end
    chk("t5_first_tick", found, 4);

    // All red for a long time: elapsed saturates
    set_lights(8'h00); rst_count = 1'b1;
    step_cycle(); rst_count = 1'b0;
    for (int k = 0; k < 260 * C; k++) step_cycle();
    chk("sat_elapsed", int'(elapsed), 255);

    // Two greens for one cycle: sticky fault
    set_lights(8'b10_10_00_00);
    step_cycle();
    chk("t6_fault", int'(fault), 1);
    chk("t6_five", int'(five_sec_timer), 0);
    set_lights(8'b10_00_00_00); car_req = 4'b0000;
    for (int k = 0; k < 30; k++) step_cycle();
    chk("t6_fault_hold", int'(fault), 1);
    chk("t6_five_hold", int'(five_sec_timer), 0);
    do_reset();

    // Randomized phase sequences
    for (int seg = 0; seg < 150; seg++) begin
      int r, len, d;
      r = int'($urandom_range(0, 15));
      len = int'($urandom_range(2, 40));
      l = 8'h00;
      if (r <= 3 || r >= 11) begin
        d = (r <= 3) ? r : int'($urandom_range(0, 3));
        l[2*d +: 2] = 2'b10;
      end else if (r <= 7) begin
        logic [3:0] m;
        m = 4'($urandom_range(1, 14));
        for (int i = 0; i < 4; i++) if (m[i]) l[2*i +: 2] = 2'b01;
      end else if (r == 8) begin
        l = 8'b01_01_01_01;
      end else if (r == 10) begin
        l = 8'($urandom);
      end
      set_lights(l);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) car_req = 4'($urandom);
        rst_count = (c == 0) || ($urandom_range(0, 59) == 0);
        step_cycle();
        if ((m_five != 0 || m_one != 0) && $urandom_range(0, 3) == 0) break;
      end
      rst_count = 1'b0;
      if (m_fault != 0 || $urandom_range(0, 19) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
